// File: rtl/el2_mubi_pkg.sv
// Multi-bit (MuBi4) boolean encoding shared across the EL2 safety blocks.
package el2_mubi_pkg;

  typedef logic [3:0] el2_mubi_t;

  localparam el2_mubi_t El2MuBi4True  = 4'h6;
  localparam el2_mubi_t El2MuBi4False = 4'h9;

  // Anything that is not exactly False is treated as True, so a corrupted
  // alarm line can never be silently dropped.
  function automatic logic el2_mubi4_is_true_failsafe(input el2_mubi_t val);
    return val != El2MuBi4False;
  endfunction

  function automatic logic el2_mubi4_is_canonical(input el2_mubi_t val);
    return (val == El2MuBi4True) || (val == El2MuBi4False);
  endfunction

endpackage

// File: rtl/el2_pkg.sv
// Shared EL2 core types.
package el2_pkg;

  typedef enum logic [1:0] {
    LsAlmIdle  = 2'd0,
    LsAlmNmi   = 2'd1,
    LsAlmReset = 2'd2
  } el2_ls_alarm_state_e;

endpackage

// File: rtl/el2_sat_counter.sv
// Saturating up-counter with synchronous clear; an increment beats a clear.
module el2_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o,
  output logic [W-1:0] cnt_next_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic [W-1:0] cnt_inc;

  always_comb begin
    cnt_inc = cnt_q;
    if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_inc = cnt_q + W'(1);
    end
    cnt_d = cnt_inc;
    if (clr_i && !inc_i) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o      = cnt_q;
  assign cnt_next_o = cnt_inc;

endmodule

// File: rtl/el2_lockstep_alarm_handler.sv
// Consumes the lockstep checker alarm: counts corruption events and escalates
// from NMI to a core reset request on missing ack or too many events.
module el2_lockstep_alarm_handler
  import el2_mubi_pkg::*;
  import el2_pkg::*;
#(
  parameter int ESC_TIMEOUT = 64,
  parameter int ESC_THRESH  = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  el2_mubi_t        corruption_detected_i,
  input  el2_mubi_t        esc_disable_i,
  input  logic             nmi_ack_i,
  input  logic             clr_i,
  output logic             nmi_int_o,
  output logic             rst_req_o,
  output el2_mubi_t        alarm_sticky_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic             invalid_mubi_o,
  output logic [1:0]       state_o
);

  localparam int TMR_W = (ESC_TIMEOUT > 2) ? $clog2(ESC_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(ESC_TIMEOUT - 1);

  localparam logic [1:0] StIdle  = LsAlmIdle;
  localparam logic [1:0] StNmi   = LsAlmNmi;
  localparam logic [1:0] StReset = LsAlmReset;

  logic             det;
  logic             esc_dis;
  logic             evt;
  logic             clr_ok;
  logic             thresh_hit;
  logic [CNT_W-1:0] cnt_next;

  logic             det_q,     det_d;
  logic [1:0]       state_q,   state_d;
  logic [TMR_W-1:0] timer_q,   timer_d;
  el2_mubi_t        sticky_q,  sticky_d;
  logic             invalid_q, invalid_d;

  // Invalid esc_disable encodings fall back to False: escalation stays enabled.
  assign det     = el2_mubi4_is_true_failsafe(corruption_detected_i);
  assign esc_dis = (esc_disable_i == El2MuBi4True);
  assign evt     = det & ~det_q;
  assign clr_ok  = clr_i && (state_q == StIdle) && !evt;

  el2_sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk        (clk),
    .rst        (rst),
    .inc_i      (evt),
    .clr_i      (clr_ok),
    .cnt_o      (err_cnt_o),
    .cnt_next_o (cnt_next)
  );

  assign thresh_hit = 32'(cnt_next) >= 32'(ESC_THRESH);

  always_comb begin
    det_d     = det;
    invalid_d = invalid_q | ~el2_mubi4_is_canonical(corruption_detected_i)
                          | ~el2_mubi4_is_canonical(esc_disable_i);
    sticky_d  = sticky_q;
    if (evt) begin
      sticky_d = El2MuBi4True;
    end else if (clr_ok) begin
      sticky_d = El2MuBi4False;
    end

    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      StIdle: begin
        timer_d = '0;
        if (evt) begin
          state_d = (thresh_hit && !esc_dis) ? StReset : StNmi;
        end
      end
      StNmi: begin
        // The timer parks at its maximum so a disabled escalation holds NMI.
        if (timer_q != TMR_MAX) begin
          timer_d = timer_q + TMR_W'(1);
        end
        if (nmi_ack_i) begin
          state_d = StIdle;
          timer_d = '0;
        end else if (!esc_dis && ((timer_q == TMR_MAX) || thresh_hit)) begin
          state_d = StReset;
        end
      end
      StReset: begin
        state_d = StReset;
      end
      default: begin
        state_d = StReset;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      det_q     <= 1'b0;
      state_q   <= StIdle;
      timer_q   <= '0;
      sticky_q  <= El2MuBi4False;
      invalid_q <= 1'b0;
    end else begin
      det_q     <= det_d;
      state_q   <= state_d;
      timer_q   <= timer_d;
      sticky_q  <= sticky_d;
      invalid_q <= invalid_d;
    end
  end

  assign nmi_int_o      = (state_q == StNmi);
  assign rst_req_o      = (state_q == StReset);
  assign alarm_sticky_o = sticky_q;
  assign invalid_mubi_o = invalid_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_el2_lockstep_alarm_handler.sv
// Directed bench for el2_lockstep_alarm_handler: vector table plus escalation sequences.
module tb_el2_lockstep_alarm_handler;

  localparam int ESC_TIMEOUT = 64;
  localparam int ESC_THRESH  = 4;
  localparam int CNT_W       = 8;

  localparam logic [3:0] T = 4'h6;
  localparam logic [3:0] F = 4'h9;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       corr;
  logic [3:0]       dis;
  logic             ack;
  logic             clr;
  logic             nmi_int;
  logic             rst_req;
  logic [3:0]       sticky;
  logic [CNT_W-1:0] err_cnt;
  logic             invalid;
  logic [1:0]       state;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic       rst;
    logic [3:0] corr;
    logic [3:0] dis;
    logic       ack;
    logic       clr;
    logic       e_nmi;
    logic       e_rr;
    logic [3:0] e_sticky;
    logic [7:0] e_cnt;
    logic       e_inv;
    logic [1:0] e_st;
  } vec_t;

  vec_t vq[$];

  always #5 clk = ~clk;

  el2_lockstep_alarm_handler #(
    .ESC_TIMEOUT (ESC_TIMEOUT),
    .ESC_THRESH  (ESC_THRESH),
    .CNT_W       (CNT_W)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .corruption_detected_i (corr),
    .esc_disable_i         (dis),
    .nmi_ack_i             (ack),
    .clr_i                 (clr),
    .nmi_int_o             (nmi_int),
    .rst_req_o             (rst_req),
    .alarm_sticky_o        (sticky),
    .err_cnt_o             (err_cnt),
    .invalid_mubi_o        (invalid),
    .state_o               (state)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic e_nmi, input logic e_rr,
                            input logic [3:0] e_sticky, input logic [7:0] e_cnt,
                            input logic e_inv, input logic [1:0] e_st);
    chk({tag, ".nmi"},     32'(nmi_int), 32'(e_nmi));
    chk({tag, ".rst_req"}, 32'(rst_req), 32'(e_rr));
    chk({tag, ".sticky"},  32'(sticky),  32'(e_sticky));
    chk({tag, ".cnt"},     32'(err_cnt), 32'(e_cnt));
    chk({tag, ".invalid"}, 32'(invalid), 32'(e_inv));
    chk({tag, ".state"},   32'(state),   32'(e_st));
  endtask

  // Drive one cycle of inputs; outputs are sampled 1 time unit after the edge.
  task automatic step(input logic r, input logic [3:0] c, input logic [3:0] d,
                      input logic a, input logic cl);
    rst  = r;
    corr = c;
    dis  = d;
    ack  = a;
    clr  = cl;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic r, input logic [3:0] c, input logic [3:0] d,
                     input logic a, input logic cl, input logic e_nmi, input logic e_rr,
                     input logic [3:0] e_sticky, input logic [7:0] e_cnt,
                     input logic e_inv, input logic [1:0] e_st);
    vec_t v;
    v.rst = r; v.corr = c; v.dis = d; v.ack = a; v.clr = cl;
    v.e_nmi = e_nmi; v.e_rr = e_rr; v.e_sticky = e_sticky;
    v.e_cnt = e_cnt; v.e_inv = e_inv; v.e_st = e_st;
    vq.push_back(v);
  endtask

  task automatic do_reset();
    step(1'b1, F, F, 1'b0, 1'b0);
    step(1'b1, F, F, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; corr = F; dis = F; ack = 1'b0; clr = 1'b0;

    // Reset for 3 cycles, then 20 quiet cycles.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, F, F, 1'b0, 1'b0);
      check_outs($sformatf("rst%0d", i), 1'b0, 1'b0, F, 8'd0, 1'b0, 2'd0);
    end
    for (int i = 0; i < 20; i++) begin
      step(1'b0, F, F, 1'b0, 1'b0);
      check_outs($sformatf("idle%0d", i), 1'b0, 1'b0, F, 8'd0, 1'b0, 2'd0);
    end

    //   rst  corr dis  ack   clr   nmi   rr    stky cnt    inv   st
    add(1'b0, T,   F,   1'b0, 1'b0, 1'b1, 1'b0, T,   8'd1, 1'b0, 2'd1); // single pulse
    add(1'b0, F,   F,   1'b0, 1'b0, 1'b1, 1'b0, T,   8'd1, 1'b0, 2'd1);
    add(1'b0, F,   F,   1'b0, 1'b0, 1'b1, 1'b0, T,   8'd1, 1'b0, 2'd1);
    add(1'b0, F,   F,   1'b1, 1'b0, 1'b0, 1'b0, T,   8'd1, 1'b0, 2'd0); // ack
    add(1'b0, F,   F,   1'b0, 1'b0, 1'b0, 1'b0, T,   8'd1, 1'b0, 2'd0);
    add(1'b0, T,   F,   1'b0, 1'b1, 1'b1, 1'b0, T,   8'd2, 1'b0, 2'd1); // clr + event
    add(1'b0, F,   F,   1'b0, 1'b1, 1'b1, 1'b0, T,   8'd2, 1'b0, 2'd1); // clr in NMI
    add(1'b0, F,   F,   1'b1, 1'b0, 1'b0, 1'b0, T,   8'd2, 1'b0, 2'd0);
    add(1'b0, F,   F,   1'b0, 1'b1, 1'b0, 1'b0, F,   8'd0, 1'b0, 2'd0); // clr in IDLE
    add(1'b0, 4'h0, F,  1'b0, 1'b0, 1'b1, 1'b0, T,   8'd1, 1'b1, 2'd1); // invalid held
    add(1'b0, 4'h0, F,  1'b0, 1'b0, 1'b1, 1'b0, T,   8'd1, 1'b1, 2'd1);
    add(1'b0, 4'h0, F,  1'b0, 1'b0, 1'b1, 1'b0, T,   8'd1, 1'b1, 2'd1);
    add(1'b0, 4'h0, F,  1'b0, 1'b0, 1'b1, 1'b0, T,   8'd1, 1'b1, 2'd1);
    add(1'b0, F,   F,   1'b1, 1'b0, 1'b0, 1'b0, T,   8'd1, 1'b1, 2'd0);
    add(1'b0, F,   F,   1'b0, 1'b1, 1'b0, 1'b0, F,   8'd0, 1'b1, 2'd0); // clr keeps invalid
    add(1'b1, F,   F,   1'b0, 1'b0, 1'b0, 1'b0, F,   8'd0, 1'b0, 2'd0);
    add(1'b0, F,   4'h3, 1'b0, 1'b0, 1'b0, 1'b0, F,  8'd0, 1'b1, 2'd0); // invalid disable
    add(1'b0, F,   F,   1'b1, 1'b0, 1'b0, 1'b0, F,   8'd0, 1'b1, 2'd0); // ack in IDLE
    add(1'b1, F,   F,   1'b0, 1'b0, 1'b0, 1'b0, F,   8'd0, 1'b0, 2'd0);

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].rst, vq[i].corr, vq[i].dis, vq[i].ack, vq[i].clr);
      check_outs($sformatf("vec%0d", i), vq[i].e_nmi, vq[i].e_rr, vq[i].e_sticky,
                 vq[i].e_cnt, vq[i].e_inv, vq[i].e_st);
    end

    // Unacknowledged NMI lasts ESC_TIMEOUT cycles, then reset is requested.
    do_reset();
    step(1'b0, T, F, 1'b0, 1'b0);
    check_outs("to_first", 1'b1, 1'b0, T, 8'd1, 1'b0, 2'd1);
    for (int i = 1; i < ESC_TIMEOUT; i++) begin
      step(1'b0, F, F, 1'b0, 1'b0);
      check_outs($sformatf("to_nmi%0d", i), 1'b1, 1'b0, T, 8'd1, 1'b0, 2'd1);
    end
    step(1'b0, F, F, 1'b0, 1'b0);
    check_outs("to_rst", 1'b0, 1'b1, T, 8'd1, 1'b0, 2'd2);
    step(1'b0, F, F, 1'b1, 1'b1);
    check_outs("to_hold_ack", 1'b0, 1'b1, T, 8'd1, 1'b0, 2'd2);
    step(1'b0, T, T, 1'b1, 1'b1);
    check_outs("to_hold_evt", 1'b0, 1'b1, T, 8'd2, 1'b0, 2'd2);
    step(1'b1, F, F, 1'b0, 1'b0);
    check_outs("to_rst_pulse", 1'b0, 1'b0, F, 8'd0, 1'b0, 2'd0);

    // Escalation disabled: NMI held with no reset request, ack still returns to IDLE.
    do_reset();
    step(1'b0, T, T, 1'b0, 1'b0);
    check_outs("dis_first", 1'b1, 1'b0, T, 8'd1, 1'b0, 2'd1);
    for (int i = 0; i < 500; i++) begin
      step(1'b0, F, T, 1'b0, 1'b0);
      chk($sformatf("dis_nmi%0d", i), 32'(nmi_int), 32'd1);
      chk($sformatf("dis_rr%0d", i), 32'(rst_req), 32'd0);
    end
    step(1'b0, F, T, 1'b1, 1'b0);
    check_outs("dis_ack", 1'b0, 1'b0, T, 8'd1, 1'b0, 2'd0);

    // Threshold: four pulses 5 cycles apart, no ack.
    do_reset();
    for (int p = 1; p <= 4; p++) begin
      step(1'b0, T, F, 1'b0, 1'b0);
      check_outs($sformatf("th_p%0d", p), p < 4, p == 4, T, 8'(p), 1'b0,
                 (p < 4) ? 2'd1 : 2'd2);
      if (p < 4) begin
        for (int k = 0; k < 4; k++) step(1'b0, F, F, 1'b0, 1'b0);
      end
    end
    step(1'b0, F, F, 1'b0, 1'b0);
    check_outs("th_hold", 1'b0, 1'b1, T, 8'd4, 1'b0, 2'd2);

    // Threshold variant: ack arrives with the fourth pulse, ack wins.
    do_reset();
    for (int p = 1; p <= 4; p++) begin
      step(1'b0, T, F, p == 4, 1'b0);
      check_outs($sformatf("tha_p%0d", p), p < 4, 1'b0, T, 8'(p), 1'b0,
                 (p < 4) ? 2'd1 : 2'd0);
      if (p < 4) begin
        for (int k = 0; k < 4; k++) step(1'b0, F, F, 1'b0, 1'b0);
      end
    end
    for (int k = 0; k < 3; k++) begin
      step(1'b0, F, F, 1'b0, 1'b0);
      check_outs($sformatf("tha_idle%0d", k), 1'b0, 1'b0, T, 8'd4, 1'b0, 2'd0);
    end

    // Event in IDLE already at threshold goes straight to RESET.
    step(1'b0, T, F, 1'b0, 1'b0);
    check_outs("th_direct", 1'b0, 1'b1, T, 8'd5, 1'b0, 2'd2);

    // Reset asserted mid-NMI leaves nothing behind.
    do_reset();
    step(1'b0, T, F, 1'b0, 1'b0);
    step(1'b1, F, F, 1'b0, 1'b0);
    check_outs("mid_rst", 1'b0, 1'b0, F, 8'd0, 1'b0, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
